// File: rtl/param_alu_datapath.sv
// Multicycle register-file/ALU datapath with a built-in IDLE->DECODE->EXEC->
// WRITEBACK sequencer. One 16-bit CR16-style instruction is accepted per
// valid/ready handshake; results and PSR flags commit in WRITEBACK.
module param_alu_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int IMM_W = 8,
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    input  logic             ext_load,
    input  logic [AW-1:0]    ext_addr,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic [4:0]       flags,
    output logic             illegal,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    // Opcodes are shared by the R form (instr[7:4]) and the I form (instr[15:12]).
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [15:0]        instr_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [3:0]         op_q;
    logic [AW-1:0]      rdest_q;
    logic               bad_q;
    logic [4:0]         flags_q, nflags_q;

    // Decode-stage signals
    logic               dec_is_r, dec_logic, dec_op_ok, dec_bad;
    logic [3:0]         dec_op, dec_rdest, dec_rsrc;
    logic [IMM_W-1:0]   dec_imm;
    logic [WIDTH-1:0]   a_d, b_d, rsrc_val;

    // Exec-stage signals
    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   res_d;
    logic [4:0]         nflags_d;
    logic               fc_d, fl_d, ff_d, fz_d, fn_d;

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: only IDLE waits, on an accepted handshake
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (instr_valid && instr_ready) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Instruction field decode and operand fetch from the latched instruction
    always_comb begin
        dec_is_r  = (instr_q[15:12] == 4'b0000);
        dec_op    = dec_is_r ? instr_q[7:4] : instr_q[15:12];
        dec_rdest = instr_q[11:8];
        dec_rsrc  = instr_q[3:0];
        dec_imm   = instr_q[IMM_W-1:0];
        dec_logic = (dec_op == OP_AND) || (dec_op == OP_OR) || (dec_op == OP_XOR);
        dec_op_ok = dec_logic || (dec_op == OP_ADD) || (dec_op == OP_SUB) ||
                    (dec_op == OP_CMP) || (dec_op == OP_MOV);
        dec_bad   = !dec_op_ok || (int'(dec_rdest) >= NREGS) ||
                    (dec_is_r && (int'(dec_rsrc) >= NREGS));
        a_d       = (int'(dec_rdest) < NREGS) ? regs_q[dec_rdest[AW-1:0]] : '0;
        rsrc_val  = (int'(dec_rsrc) < NREGS) ? regs_q[dec_rsrc[AW-1:0]] : '0;
        // Logical ops zero-extend the immediate; arithmetic and MOV sign-extend it.
        if (dec_is_r)       b_d = rsrc_val;
        else if (dec_logic) b_d = WIDTH'(dec_imm);
        else                b_d = WIDTH'($signed(dec_imm));
    end

    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    // ALU result and next PSR; flags not touched by an op keep their value
    always_comb begin
        res_d = b_q;
        fc_d  = flags_q[4];
        fl_d  = flags_q[3];
        ff_d  = flags_q[2];
        fz_d  = flags_q[1];
        fn_d  = flags_q[0];
        case (op_q)
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_XOR: res_d = a_q ^ b_q;
            OP_ADD: begin
                res_d = sum_w[MSB:0];
                fc_d  = sum_w[WIDTH];
                ff_d  = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                res_d = diff_w[MSB:0];
                fc_d  = diff_w[WIDTH];
                ff_d  = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
            end
            OP_CMP: begin
                fz_d = (a_q == b_q);
                fl_d = (a_q < b_q);
                fn_d = ($signed(a_q) < $signed(b_q));
            end
            default: res_d = b_q;
        endcase
        if (op_q != OP_CMP) begin
            fz_d = (res_d == '0);
            fn_d = res_d[MSB];
        end
        nflags_d = {fc_d, fl_d, ff_d, fz_d, fn_d};
    end

    // Pipeline holding registers and PSR, advanced once per sequencer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rdest_q  <= '0;
            bad_q    <= 1'b0;
            res_q    <= '0;
            nflags_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (instr_valid && instr_ready) instr_q <= instr;
                S_DECODE: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    op_q    <= dec_op;
                    rdest_q <= dec_rdest[AW-1:0];
                    bad_q   <= dec_bad;
                end
                S_EXEC: begin
                    res_q    <= res_d;
                    nflags_q <= nflags_d;
                end
                S_WB: if (!bad_q) flags_q <= nflags_q;
                default: ;
            endcase
        end
    end

    // Register file: external load in IDLE, instruction result in WRITEBACK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is architecturally cleared by reset, so it is built from flops, not a RAM macro.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (state_q == S_IDLE) begin
            if (ext_load && (int'(ext_addr) < NREGS)) regs_q[ext_addr] <= ext_data;
        end else if (wb_valid) begin
            regs_q[rdest_q] <= res_q;
        end
    end

    assign instr_ready = (state_q == S_IDLE) && !ext_load;
    assign busy        = (state_q != S_IDLE);
    assign wb_valid    = (state_q == S_WB) && !bad_q && (op_q != OP_CMP);
    assign illegal     = (state_q == S_WB) && bad_q;
    assign wb_addr     = rdest_q;
    assign wb_data     = res_q;
    assign flags       = flags_q;
    assign dbg_data    = (int'(dbg_addr) < NREGS) ? regs_q[dbg_addr] : '0;

endmodule

// File: tb/tb_param_alu_datapath.sv
// Directed bench for param_alu_datapath: a 16x16 main instance, an 8-register
// instance sharing its inputs (out-of-range destination), and an 8-bit/4-register
// instance selected with sel_s. Expected values are hand-computed.
module tb_param_alu_datapath;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel_s, instr_valid, ext_load;
    logic [15:0] instr, ext_data;
    logic [3:0]  ext_addr, dbg_addr;
    logic [2:0]  n_dbg_addr;

    logic        m_valid, s_valid, m_load, s_load;
    assign m_valid = instr_valid & ~sel_s;
    assign s_valid = instr_valid &  sel_s;
    assign m_load  = ext_load & ~sel_s;
    assign s_load  = ext_load &  sel_s;

    logic        m_ready, m_wbv, m_ill, m_busy;
    logic [15:0] m_dbg, m_wbd;
    logic [3:0]  m_wba;
    logic [4:0]  m_flags;
    logic        n_ready, n_wbv, n_ill, n_busy;
    logic [15:0] n_dbg, n_wbd;
    logic [2:0]  n_wba;
    logic [4:0]  n_flags;
    logic        s_ready, s_wbv, s_ill, s_busy;
    logic [7:0]  s_dbg, s_wbd;
    logic [1:0]  s_wba;
    logic [4:0]  s_flags;

    param_alu_datapath #(.WIDTH(16), .NREGS(16)) u_main (
        .clk(clk), .reset(reset), .instr_valid(m_valid), .instr_ready(m_ready), .instr(instr),
        .ext_load(m_load), .ext_addr(ext_addr), .ext_data(ext_data), .dbg_addr(dbg_addr),
        .dbg_data(m_dbg), .wb_valid(m_wbv), .wb_addr(m_wba), .wb_data(m_wbd),
        .flags(m_flags), .illegal(m_ill), .busy(m_busy));

    param_alu_datapath #(.WIDTH(16), .NREGS(8)) u_n8 (
        .clk(clk), .reset(reset), .instr_valid(m_valid), .instr_ready(n_ready), .instr(instr),
        .ext_load(m_load), .ext_addr(ext_addr[2:0]), .ext_data(ext_data), .dbg_addr(n_dbg_addr),
        .dbg_data(n_dbg), .wb_valid(n_wbv), .wb_addr(n_wba), .wb_data(n_wbd),
        .flags(n_flags), .illegal(n_ill), .busy(n_busy));

    param_alu_datapath #(.WIDTH(8), .NREGS(4)) u_small (
        .clk(clk), .reset(reset), .instr_valid(s_valid), .instr_ready(s_ready), .instr(instr),
        .ext_load(s_load), .ext_addr(ext_addr[1:0]), .ext_data(ext_data[7:0]), .dbg_addr(dbg_addr[1:0]),
        .dbg_data(s_dbg), .wb_valid(s_wbv), .wb_addr(s_wba), .wb_data(s_wbd),
        .flags(s_flags), .illegal(s_ill), .busy(s_busy));

    // View of whichever of main/small is selected
    logic        sel_ready, sel_wbv, sel_ill;
    logic [15:0] sel_dbg, sel_wbd;
    logic [3:0]  sel_wba;
    logic [4:0]  sel_flags;
    assign sel_ready = sel_s ? s_ready : m_ready;
    assign sel_wbv   = sel_s ? s_wbv : m_wbv;
    assign sel_ill   = sel_s ? s_ill : m_ill;
    assign sel_dbg   = sel_s ? {8'h00, s_dbg} : m_dbg;
    assign sel_wbd   = sel_s ? {8'h00, s_wbd} : m_wbd;
    assign sel_wba   = sel_s ? {2'b00, s_wba} : m_wba;
    assign sel_flags = sel_s ? s_flags : m_flags;

    int          checks = 0;
    int          errors = 0;
    int          wb_cnt, ill_cnt, n_wb_cnt, n_ill_cnt;
    logic [3:0]  last_wba;
    logic [15:0] last_wbd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        ext_load = 1'b1; ext_addr = a; ext_data = d;
        @(negedge clk);
        ext_load = 1'b0;
    endtask

    // Offer one instruction in IDLE, then watch DECODE/EXEC/WRITEBACK; returns in IDLE after commit.
    task automatic issue(input logic [15:0] i);
        @(negedge clk);
        instr = i; instr_valid = 1'b1;
        #1 check("ready in idle", sel_ready, 1);
        wb_cnt = 0; ill_cnt = 0; n_wb_cnt = 0; n_ill_cnt = 0;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) begin
            if (sel_wbv) begin wb_cnt++; last_wba = sel_wba; last_wbd = sel_wbd; end
            if (sel_ill) ill_cnt++;
            if (n_wbv)   n_wb_cnt++;
            if (n_ill)   n_ill_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] r, input logic [15:0] v);
        dbg_addr = r;
        #1 check(tag, sel_dbg, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, bad;
        reset = 1'b1; sel_s = 1'b0; instr_valid = 1'b0; ext_load = 1'b0;
        instr = '0; ext_addr = '0; ext_data = '0; dbg_addr = '0; n_dbg_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset ready", m_ready, 1);
        check("reset busy", m_busy, 0);
        check("reset flags", m_flags, 0);
        check("reset wb_valid", m_wbv, 0);
        check("reset illegal", m_ill, 0);
        expect_reg("reset r1", 4'd1, 16'h0000);

        // ADD R2,R1: 5 + 3
        load(4'd1, 16'h0005); load(4'd2, 16'h0003);
        issue(16'h0152);
        check("add wb count", wb_cnt, 1);
        check("add wb addr", last_wba, 1);
        check("add wb data", last_wbd, 16'h0008);
        expect_reg("add r1", 4'd1, 16'h0008);
        check("add flags", m_flags, 5'b00000);

        // ADDI overflow 0x7FFF+1, then SUBI with sign-extended 0xFF80
        load(4'd3, 16'h7FFF);
        issue(16'h5301);
        expect_reg("addi r3", 4'd3, 16'h8000);
        check("addi flags", m_flags, 5'b00101);
        issue(16'h9380);
        expect_reg("subi r3", 4'd3, 16'h8080);
        check("subi flags", m_flags, 5'b10001);

        // CMP R5,R4 (A=2, B=0xFFFE) then CMPI R4,#2
        load(4'd4, 16'h0002); load(4'd5, 16'hFFFE);
        issue(16'h04B5);
        check("cmp no wb", wb_cnt, 0);
        check("cmp flags", m_flags, 5'b11000);
        expect_reg("cmp r4", 4'd4, 16'h0002);
        issue(16'hB402);
        check("cmpi flags", m_flags, 5'b10010);

        // Undefined R-type op 0111
        issue(16'h0071);
        check("bad op illegal", ill_cnt, 1);
        check("bad op no wb", wb_cnt, 0);
        check("bad op flags", m_flags, 5'b10010);
        expect_reg("bad op r0", 4'd0, 16'h0000);

        // Back-to-back MOVI R6,#0x55 with instr_valid held high for 12 cycles
        @(negedge clk);
        instr = 16'hD655; instr_valid = 1'b1; acc = 0; bad = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (m_ready) acc++;
            if (m_ready !== (k % 4 == 0)) bad++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("b2b accepts", acc, 3);
        check("b2b ready pattern errors", bad, 0);
        expect_reg("movi r6", 4'd6, 16'h0055);
        check("movi flags", m_flags, 5'b10000);

        // XORI zero-extends 0xFF
        issue(16'h36FF);
        expect_reg("xori r6", 4'd6, 16'h00AA);
        check("xori flags", m_flags, 5'b10000);

        // ext_load and instr_valid together: load wins, MOV R8,R7 accepted next cycle
        @(negedge clk);
        ext_load = 1'b1; ext_addr = 4'd7; ext_data = 16'h1234;
        instr = 16'h08D7; instr_valid = 1'b1;
        #1 check("load blocks ready", m_ready, 0);
        @(negedge clk);
        ext_load = 1'b0;
        #1 check("ready after load", m_ready, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        expect_reg("mov r8", 4'd8, 16'h1234);
        expect_reg("load r7", 4'd7, 16'h1234);

        // SUB R8,R8: same source and destination
        issue(16'h0898);
        expect_reg("sub self r8", 4'd8, 16'h0000);
        check("sub self flags", m_flags, 5'b00010);

        // Reset asserted during EXEC of ADD R2,R1
        @(negedge clk);
        instr = 16'h0152; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1 check("busy in exec", m_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort ready", m_ready, 1);
        check("abort busy", m_busy, 0);
        check("abort wb_valid", m_wbv, 0);
        check("abort flags", m_flags, 0);
        expect_reg("abort r1", 4'd1, 16'h0000);
        @(negedge clk);
        #1 check("abort ready next", m_ready, 1);
        expect_reg("abort r1 next", 4'd1, 16'h0000);

        // ADDI R9,#-1: legal on 16 regs, out of range on 8 regs
        n_dbg_addr = 3'd1;
        issue(16'h59FF);
        check("r9 wb addr", last_wba, 9);
        expect_reg("addi r9", 4'd9, 16'hFFFF);
        check("addi r9 flags", m_flags, 5'b00001);
        check("n8 illegal", n_ill_cnt, 1);
        check("n8 no wb", n_wb_cnt, 0);
        check("n8 flags", n_flags, 5'b00000);
        check("n8 r1", n_dbg, 16'h0000);

        // WIDTH=8, NREGS=4 instance
        sel_s = 1'b1;
        load(4'd1, 16'h007F); load(4'd2, 16'h0001);
        issue(16'h0152);
        check("w8 add wb", wb_cnt, 1);
        expect_reg("w8 add r1", 4'd1, 16'h0080);
        check("w8 add flags", s_flags, 5'b00101);
        load(4'd3, 16'h00FF);
        issue(16'h5301);
        expect_reg("w8 addi wrap r3", 4'd3, 16'h0000);
        check("w8 addi flags", s_flags, 5'b10010);
        issue(16'h9301);
        expect_reg("w8 subi r3", 4'd3, 16'h00FF);
        check("w8 subi flags", s_flags, 5'b10001);
        issue(16'h02B3);
        check("w8 cmp no wb", wb_cnt, 0);
        check("w8 cmp flags", s_flags, 5'b11000);
        issue(16'h5501);
        check("w8 rdest5 illegal", ill_cnt, 1);
        check("w8 rdest5 no wb", wb_cnt, 0);
        check("w8 rdest5 flags", s_flags, 5'b11000);
        expect_reg("w8 rdest5 r1", 4'd1, 16'h0080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_alu_datapath.md
Name: param_alu_datapath

Overview:
Parametrised multicycle register-file/ALU datapath with a built-in sequencer. It accepts one 16-bit CR16-style instruction per transaction over a valid/ready handshake. Each instruction runs DECODE -> EXEC -> WRITEBACK, updates a PSR flag register and optionally writes the result back to the register file. An external load port and a debug read port let benches and a future memory stage preload and observe registers.

Parameters:
WIDTH, 16, datapath and register width in bits (8..32)
NREGS, 16, number of registers (2..16); AW = clog2(NREGS)
IMM_W, 8, immediate field width taken from instr[IMM_W-1:0] (fixed 8 in this revision)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  datapath can accept an instruction this cycle
instr  in  16  instruction word
ext_load  in  1  write ext_data to register ext_addr
ext_addr  in  AW  external write address
ext_data  in  WIDTH  external write data
dbg_addr  in  AW  debug read address
dbg_data  out  WIDTH  combinational read of reg[dbg_addr]
wb_valid  out  1  one-cycle pulse: register written by an instruction
wb_addr  out  AW  destination of that write
wb_data  out  WIDTH  value written
flags  out  5  PSR {C,L,F,Z,N}
illegal  out  1  one-cycle pulse: bad opcode or register index >= NREGS
busy  out  1  state != IDLE

Behaviour:
- Reset (async): all registers 0, flags 0, state IDLE; wb_valid, illegal, busy = 0. instr_ready = 1 after reset. Reset mid-instruction aborts it with no writeback.
- States: IDLE -> DECODE -> EXEC -> WRITEBACK -> IDLE. Transitions are unconditional except IDLE.
- IDLE: instr_ready = !ext_load. ext_load has priority and writes reg[ext_addr] at the clock edge. Handshake = instr_valid && instr_ready: latch instr and go to DECODE. instr_ready = 0 in all other states; ext_load is ignored outside IDLE.
- Decode, R-type (instr[15:12]==0000): op = instr[7:4], rdest = instr[11:8], src = reg[instr[3:0]].
- Decode, I-type: op = instr[15:12], rdest = instr[11:8], src = imm.
- Immediate extension: sign-extended to WIDTH for ADD/SUB/CMP/MOV, zero-extended for AND/OR/XOR.
- DECODE: latch A = reg[rdest] and B = src. A register index >= NREGS, or an op outside the table, marks the instruction illegal.
- Op table (same code for R and I forms): AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101.
- EXEC: compute result and next flags into holding registers.
- ADD: R = A+B mod 2^WIDTH; C = carry out; F = signed overflow.
- SUB: R = A-B; C = borrow (A<B unsigned); F = signed overflow.
- CMP: no result; Z = (A==B), L = (A<B unsigned), N = (A<B signed); C and F unchanged.
- ADD/SUB/AND/OR/XOR/MOV: Z = (R==0), N = R[WIDTH-1]; L unchanged. AND/OR/XOR/MOV also leave C and F unchanged.
- MOV: R = B.
- WRITEBACK: flags updated. For every op except CMP, reg[rdest] <= R and wb_valid pulses with wb_addr/wb_data.
- Illegal instruction: no register or flag change, no wb_valid; illegal pulses in WRITEBACK; still takes 4 cycles.
- Latency: handshake at edge E0; register and flags update at edge E0+3; next instruction can be accepted at E0+4; the result is visible on dbg_data after E0+3.
- Throughput: one instruction per 4 cycles.
- Same-register source and destination is legal (reads happen in DECODE).
- Wrap-around is modulo 2^WIDTH with no saturation.

Test Plan:
- Reset then ext_load R1=0x0005, R2=0x0003; instr 0x0152 (ADD R2,R1) -> R1=0x0008 after 4 cycles; wb_valid pulse with wb_addr=1; flags C=0, Z=0, N=0.
- ext_load R3=0x7FFF; ADDI R3,#1 (0x5301) -> R3=0x8000, F=1, N=1, C=0; then SUBI R3,#0x80 (0x9380, sign-extended 0xFF80) -> R3=0x8080, C=1 (borrow), F=0.
- R4=0x0002, R5=0xFFFE; CMP R5,R4 (0x04B5) -> L=1, N=0, Z=0; no wb_valid, R4 unchanged. CMPI R4,#2 -> Z=1.
- instr_valid held high with back-to-back instructions -> instr_ready high only in IDLE, exactly one acceptance per 4 cycles. ext_load asserted with instr_valid in IDLE -> load wins, instruction accepted the next cycle.
- Opcode 0x0071 (R-type op 0111), and NREGS=8 with rdest 9 -> illegal pulses, no register or flag change.
- Assert reset during EXEC of ADD -> no writeback, all registers 0, instr_ready=1 on the next cycle.
- Rerun ADD/SUB/CMP with WIDTH=8, NREGS=4 -> flags and wrap-around correct at 8 bits.
